// File: rtl/sev_seg_pkg.sv
// -----------------------------------------------------------------------------
// sev_seg_pkg
// Shared types for the seven-segment display path.
//   digits_t    : four 4-bit digit fields {d3,d2,d1,d0}, d3 is the leftmost digit
//   arb_state_t : arbiter states, IDLE (no owner) and SHOW (one owner displayed)
//   DIGIT_W     : width of one digit field
// -----------------------------------------------------------------------------
package sev_seg_pkg;

    localparam int DIGIT_W = 4;

    typedef struct packed {
        logic [DIGIT_W-1:0] d3;
        logic [DIGIT_W-1:0] d2;
        logic [DIGIT_W-1:0] d1;
        logic [DIGIT_W-1:0] d0;
    } digits_t;

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } arb_state_t;

endpackage

// File: rtl/sev_seg_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// sev_seg_arbiter_rr_pick
// Combinational round-robin selector. Scans the request vector starting at the
// index just after i_last and wrapping around; the first active request wins.
//   i_req   : request vector
//   i_last  : index of the most recent owner (search starts at i_last+1)
//   i_excl  : when high, i_last itself may not be chosen
//   o_gnt   : one-hot winner, zero when nothing eligible
//   o_idx   : binary index of the winner
//   o_vld   : a winner was found
// -----------------------------------------------------------------------------
module sev_seg_arbiter_rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_last,
    input  logic             i_excl,
    output logic [N_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_vld
);

    logic [IDX_W-1:0] w_cand;

    // Walk N_REQ positions after i_last; i_last is visited last so it only
    // wins when nobody else asks and it is not excluded.
    always_comb begin
        o_gnt  = '0;
        o_idx  = '0;
        o_vld  = 1'b0;
        w_cand = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_cand = IDX_W'((int'(i_last) + k) % N_REQ);
            if (!o_vld && i_req[w_cand] && !(i_excl && (w_cand == i_last))) begin
                o_vld         = 1'b1;
                o_idx         = w_cand;
                o_gnt[w_cand] = 1'b1;
            end else begin
                o_vld = o_vld;
            end
        end
    end

endmodule

// File: rtl/sev_seg_arbiter.sv
// -----------------------------------------------------------------------------
// sev_seg_arbiter
// Time-shares a 4-digit seven-segment driver between N_REQ requesters using
// round-robin ownership with a minimum dwell of DWELL_CYC cycles per owner.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   req_i[N_REQ]   : level requests, dropping it releases the display
//   data_i[N_REQ]  : per-requester digits {d3,d2,d1,d0}
//   ltr_i[N_REQ]   : per-requester letter-mode select
//   gnt_o          : one-hot current owner, zero when idle
//   in3_o..in0_o   : digits to sev_seg_driver (1-cycle copy of owner data)
//   ltr_o          : letter mode to sev_seg_driver
//   busy_o         : some requester owns the display
//   switch_o       : one-cycle pulse on every new grant
// Build option: define SEV_SEG_ARB_PREEMPT_EN to make requester 0 urgent (a
// rising req_i[0] takes the display at once and cannot be displaced).
// -----------------------------------------------------------------------------
module sev_seg_arbiter
    import sev_seg_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int DWELL_CYC = 50_000_000,
    parameter int CNT_W     = $clog2(DWELL_CYC)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_i,
    input  digits_t            data_i [N_REQ],
    input  logic [N_REQ-1:0]   ltr_i,
    output logic [N_REQ-1:0]   gnt_o,
    output logic [DIGIT_W-1:0] in3_o,
    output logic [DIGIT_W-1:0] in2_o,
    output logic [DIGIT_W-1:0] in1_o,
    output logic [DIGIT_W-1:0] in0_o,
    output logic               ltr_o,
    output logic               busy_o,
    output logic               switch_o
);

    localparam int               IDX_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DWELL_CYC - 1);
    localparam logic [IDX_W-1:0] PTR_RESET  = IDX_W'(N_REQ - 1);

    arb_state_t       r_state;
    logic [N_REQ-1:0] r_gnt;
    logic [IDX_W-1:0] r_ptr;      // current owner in SHOW, last owner in IDLE
    logic [CNT_W-1:0] r_cnt;
    digits_t          r_dig;
    logic             r_ltr;
    logic             r_busy;
    logic             r_switch;

    logic [N_REQ-1:0] w_pick_gnt;
    logic [IDX_W-1:0] w_pick_idx;
    logic             w_pick_vld;
    logic             w_own_req;
    logic             w_pre;      // urgent takeover by requester 0
    logic             w_keep;     // owner may not be displaced on expiry
    logic             w_do_grant;
    logic             w_to_idle;
    logic [N_REQ-1:0] w_new_gnt;
    logic [IDX_W-1:0] w_new_idx;

    // In SHOW the current owner is excluded, so a pick always means a change.
    sev_seg_arbiter_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .i_req  (req_i),
        .i_last (r_ptr),
        .i_excl (r_state == SHOW),
        .o_gnt  (w_pick_gnt),
        .o_idx  (w_pick_idx),
        .o_vld  (w_pick_vld)
    );

    assign w_own_req = req_i[r_ptr];

`ifdef SEV_SEG_ARB_PREEMPT_EN
    logic r_req0_d;

    // Previous req_i[0], for rising-edge detection of the urgent request.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_req0_d <= 1'b0;
        end else begin
            r_req0_d <= req_i[0];
        end
    end

    assign w_pre  = (r_state == SHOW) && (r_ptr != '0) && req_i[0] && !r_req0_d;
    assign w_keep = (r_ptr == '0);
`else
    assign w_pre  = 1'b0;
    assign w_keep = 1'b0;
`endif

    // Next-owner decision: release takes priority over expiry, both use the
    // same rr pick, so simultaneous release and expiry give the same result.
    always_comb begin
        w_do_grant = 1'b0;
        w_to_idle  = 1'b0;
        w_new_gnt  = w_pick_gnt;
        w_new_idx  = w_pick_idx;
        case (r_state)
            IDLE: begin
                w_do_grant = w_pick_vld;
            end
            SHOW: begin
                if (w_pre) begin
                    w_do_grant = 1'b1;
                    w_new_gnt  = N_REQ'(1);
                    w_new_idx  = '0;
                end else if (!w_own_req) begin
                    w_do_grant = w_pick_vld;
                    w_to_idle  = !w_pick_vld;
                end else if ((r_cnt == '0) && !w_keep) begin
                    w_do_grant = w_pick_vld;
                end else begin
                    w_do_grant = 1'b0;
                end
            end
            default: begin
                w_to_idle = 1'b1;
            end
        endcase
    end

    // Arbiter FSM with registered grant, display and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_gnt    <= '0;
            r_ptr    <= PTR_RESET;
            r_cnt    <= '0;
            r_dig    <= '0;
            r_ltr    <= 1'b0;
            r_busy   <= 1'b0;
            r_switch <= 1'b0;
        end else begin
            r_switch <= w_do_grant;
            // Live copy of the owner's data; IDLE keeps the last value shown.
            if (r_state == SHOW) begin
                r_dig <= data_i[r_ptr];
                r_ltr <= ltr_i[r_ptr];
            end else begin
                r_dig <= r_dig;
                r_ltr <= r_ltr;
            end
            if (w_do_grant) begin
                r_state <= SHOW;
                r_gnt   <= w_new_gnt;
                r_ptr   <= w_new_idx;
                r_cnt   <= CNT_RELOAD;
                r_busy  <= 1'b1;
            end else if (w_to_idle) begin
                r_state <= IDLE;
                r_gnt   <= '0;
                r_cnt   <= '0;
                r_busy  <= 1'b0;
            end else begin
                r_cnt   <= (r_cnt == '0) ? '0 : (r_cnt - CNT_W'(1));
            end
        end
    end

    assign gnt_o    = r_gnt;
    assign in3_o    = r_dig.d3;
    assign in2_o    = r_dig.d2;
    assign in1_o    = r_dig.d1;
    assign in0_o    = r_dig.d0;
    assign ltr_o    = r_ltr;
    assign busy_o   = r_busy;
    assign switch_o = r_switch;

endmodule
